imm_enc: RTL

Immediate encoder for the instruction-issue path; the inverse of the immediate generator. Takes a requested constant or offset plus an immediate class (`IMM_M`, `IMM_BR`, `IMM_LDI`, `IMM_LDUI`) and emits the 25-bit `imm_src` field(s) the decoder expands. 64-bit constants that do not fit a single LDI are split into an LDI/LDUI pair. It sits between the program sequencer / constant-load front end and the instruction word assembler, with valid/ready handshakes on both sides.

---
 rtl/imm_enc_pkg.sv | 30 +++
 rtl/imm_enc_pack.sv | 60 ++++++
 rtl/imm_enc.sv | 119 +++++++++++
 3 files changed

// File: rtl/imm_enc_pkg.sv
// Shared definitions for the immediate encoder: class codes, FSM states and field positions.
// Field packing lives in imm_enc_pack; range checking is enabled by IMM_ENC_RANGE_CHECK_EN.
package imm_enc_pkg;

  localparam logic [2:0] IMM_M    = 3'd1;
  localparam logic [2:0] IMM_BR   = 3'd2;
  localparam logic [2:0] IMM_LDI  = 3'd3;
  localparam logic [2:0] IMM_LDUI = 3'd4;

  typedef enum logic [1:0] {
    IMMENC_IDLE    = 2'd0,
    IMMENC_EMIT    = 2'd1,
    IMMENC_EMIT_HI = 2'd2
  } imm_enc_state_e;

  localparam int M_SIGN_BIT   = 9;
  localparam int LDI_SIGN_BIT = 19;
  localparam int LDUI_SRC_LSB = 17;
  localparam int LDUI_SRC_MSB = 31;
  localparam int BR_FIELD_MSB = 16;
  localparam int BR_FIELD_LSB = 4;

  // True when every bit at and above msb carries the same value.
  function automatic logic is_sext(input logic [63:0] v, input int msb);
    logic [63:0] hi_mask;
    hi_mask = ~64'h0 << msb;
    return ((v & hi_mask) == hi_mask) || ((v & hi_mask) == 64'h0);
  endfunction

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational packing of a value into the imm_src field for its class, including LDI split.
// With IMM_ENC_RANGE_CHECK_EN defined, encodable reports whether the value fits its class.
module imm_enc_pack
  import imm_enc_pkg::*;
#(
  parameter int IMM_W = 25
) (
  input  logic [2:0]       sel,
  input  logic [63:0]      value,
  output logic [IMM_W-1:0] field,
  output logic             split,
  output logic [IMM_W-1:0] hi_field,
  output logic             encodable
);

  logic fits_ldi;

  always_comb begin
    field    = '0;
    hi_field = '0;
    split    = 1'b0;
    fits_ldi = is_sext(value, LDI_SIGN_BIT);
    case (sel)
      IMM_M: field[M_SIGN_BIT:0] = value[M_SIGN_BIT:0];
      IMM_BR: begin
        field[BR_FIELD_MSB]                  = value[16];
        field[BR_FIELD_MSB-1:BR_FIELD_LSB]   = value[11:0];
      end
      IMM_LDI: begin
        if (fits_ldi) begin
          field[LDI_SIGN_BIT:0] = value[LDI_SIGN_BIT:0];
        end else begin
          split          = 1'b1;
          field[16:0]    = value[16:0];
          hi_field[14:0] = value[LDUI_SRC_MSB:LDUI_SRC_LSB];
        end
      end
      IMM_LDUI: field[14:0] = value[LDUI_SRC_MSB:LDUI_SRC_LSB];
      default: ;
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  logic upper_zero;
  always_comb begin
    encodable  = 1'b0;
    upper_zero = (value[63:32] == '0);
    case (sel)
      IMM_M:    encodable = is_sext(value, M_SIGN_BIT);
      IMM_BR:   encodable = (value[63:17] == '0) && (value[15:12] == '0);
      IMM_LDI:  encodable = fits_ldi || upper_zero;
      IMM_LDUI: encodable = upper_zero;
      default:  encodable = 1'b0;
    endcase
  end
`else
  assign encodable = 1'b1;
`endif

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder: registers one imm_src field per request, splitting wide LDI into LDI+LDUI.
// Build option IMM_ENC_RANGE_CHECK_EN enables dropping unencodable requests with an err pulse.
//
//   state          | meaning
//   IMMENC_IDLE    | ready for a request; may hold a single pending field
//   IMMENC_EMIT    | LDI half of a split on the output, LDUI half latched
//   IMMENC_EMIT_HI | LDUI half on the output, waiting for its handshake
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int IMM_W = 25,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sel,
  input  logic [63:0]      req_value,
  input  logic [RD_W-1:0]  req_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_sel,
  output logic [IMM_W-1:0] out_imm,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_last,
  output logic             err,
  output logic             busy
);

  imm_enc_state_e   state, state_nxt;
  logic [IMM_W-1:0] hi_imm, hi_imm_nxt, out_imm_nxt, pk_field, pk_hi;
  logic [2:0]       out_sel_nxt;
  logic [RD_W-1:0]  out_rd_nxt;
  logic             out_valid_nxt, out_last_nxt, err_nxt;
  logic             pk_split, pk_ok, accept, take;

  imm_enc_pack #(.IMM_W(IMM_W)) u_pack (
    .sel       (req_sel),
    .value     (req_value),
    .field     (pk_field),
    .split     (pk_split),
    .hi_field  (pk_hi),
    .encodable (pk_ok)
  );

  // rst_n gates ready so nothing is accepted while reset is held.
  assign req_ready = rst_n & (state == IMMENC_IDLE) & (~out_valid | out_ready);
  assign accept    = req_valid & req_ready;
  assign take      = out_valid & out_ready;
  assign busy      = (state != IMMENC_IDLE) | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IMMENC_IDLE;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_imm   <= '0;
      out_rd    <= '0;
      out_last  <= 1'b0;
      hi_imm    <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      out_sel   <= out_sel_nxt;
      out_imm   <= out_imm_nxt;
      out_rd    <= out_rd_nxt;
      out_last  <= out_last_nxt;
      hi_imm    <= hi_imm_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    out_valid_nxt = out_valid;
    out_sel_nxt   = out_sel;
    out_imm_nxt   = out_imm;
    out_rd_nxt    = out_rd;
    out_last_nxt  = out_last;
    hi_imm_nxt    = hi_imm;
    err_nxt       = 1'b0;
    case (state)
      IMMENC_IDLE: begin
        if (take) out_valid_nxt = 1'b0;
        if (accept) begin
          if (!pk_ok) begin
            err_nxt = 1'b1;
          end else begin
            out_valid_nxt = 1'b1;
            out_sel_nxt   = req_sel;
            out_imm_nxt   = pk_field;
            out_rd_nxt    = req_rd;
            out_last_nxt  = ~pk_split;
            hi_imm_nxt    = pk_hi;
            if (pk_split) state_nxt = IMMENC_EMIT;
          end
        end
      end
      IMMENC_EMIT: begin
        if (take) begin
          out_sel_nxt  = IMM_LDUI;
          out_imm_nxt  = hi_imm;
          out_last_nxt = 1'b1;
          state_nxt    = IMMENC_EMIT_HI;
        end
      end
      IMMENC_EMIT_HI: begin
        if (take) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IMMENC_IDLE;
        end
      end
      default: state_nxt = IMMENC_IDLE;
    endcase
  end

endmodule
